// File: rtl/data_bus_controller.sv
// Clocked data bus buffer between the 65C02 core bus and the external data pins.
// One transfer at a time: request/ack handshake, wait states, RDY stretch, BE hold.
module data_bus_controller #(
  parameter int DATA_W = 8,
  parameter int WS_W   = 4
) (
  input  logic              phi2,
  input  logic              resb,
  input  logic              be,
  input  logic              rdy_in,
  input  logic              req,
  input  logic              rwb,
  input  logic [WS_W-1:0]   wait_cfg,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              ack,
  output logic              busy,
  input  logic [DATA_W-1:0] ext_din,
  output logic [DATA_W-1:0] ext_dout,
  output logic              ext_oe,
  output logic              ext_rwb
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  // Transfer attributes latched at accept; stable for the whole transfer.
  typedef struct packed {
    logic              rwb;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  state_t            state_q, state_d;
  logic [WS_W-1:0]   cnt_q, cnt_d;
  xfer_t             xfer_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic              accept, done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && be) begin
          accept  = 1'b1;
          cnt_d   = wait_cfg;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // BE low outranks both the countdown and completion.
        if (!be)                    state_d = HOLD;
        else if (cnt_q != '0)       cnt_d   = cnt_q - 1'b1;
        else if (rdy_in) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (be) state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phi2 or negedge resb) begin
    if (!resb) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      xfer_q.rwb   <= 1'b1;
      xfer_q.wdata <= '0;
      rdata_q      <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= done;
      if (accept) begin
        xfer_q.rwb <= rwb;
        if (!rwb) xfer_q.wdata <= core_wdata;
      end
      if (done && xfer_q.rwb) rdata_q <= ext_din;
    end
  end

  assign core_rdata = rdata_q;
  assign ack        = ack_q;
  assign busy       = (state_q != IDLE);
  // Combinational in be so the pin driver lets go in the same cycle BE falls.
  assign ext_oe     = (state_q == ACCESS) && !xfer_q.rwb && be;
  assign ext_rwb    = (state_q == IDLE) ? 1'b1 : xfer_q.rwb;
  assign ext_dout   = xfer_q.wdata;

endmodule

// File: tb/tb_data_bus_controller.sv
// Self-checking bench for data_bus_controller: directed scenarios plus randomized
// transfers checked cycle by cycle against a transfer-level timeline model.
module tb_data_bus_controller;
  localparam int DATA_W = 8;
  localparam int WS_W   = 4;

  logic              phi2 = 1'b0;
  logic              resb;
  logic              be, rdy_in, req, rwb;
  logic [WS_W-1:0]   wait_cfg;
  logic [DATA_W-1:0] core_wdata, core_rdata, ext_din, ext_dout;
  logic              ack, busy, ext_oe, ext_rwb;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural view of the bench: what ext_dout and core_rdata must show.
  logic [DATA_W-1:0] m_wdata, m_rdata;

  data_bus_controller #(.DATA_W(DATA_W), .WS_W(WS_W)) dut (
    .phi2(phi2), .resb(resb), .be(be), .rdy_in(rdy_in), .req(req), .rwb(rwb),
    .wait_cfg(wait_cfg), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .ack(ack), .busy(busy), .ext_din(ext_din), .ext_dout(ext_dout),
    .ext_oe(ext_oe), .ext_rwb(ext_rwb)
  );

  always #5 phi2 = ~phi2;

  // Observed vector: {busy, ack, ext_oe, ext_rwb, ext_dout, core_rdata}
  function automatic logic [19:0] obs_vec();
    return {busy, ack, ext_oe, ext_rwb, ext_dout, core_rdata};
  endfunction

  task automatic test_reset();
    logic [19:0] o, e;
    resb = 1'b0; be = 1'b1; rdy_in = 1'b1; req = 1'b0; rwb = 1'b1;
    wait_cfg = '0; core_wdata = '0; ext_din = '0;
    m_wdata = '0; m_rdata = '0;
    #3;
    o = obs_vec(); e = {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_state got=%b exp=%b", o, e); end
    @(negedge phi2); resb = 1'b1;
  endtask

  // One transfer. Timeline after the accept edge, cycle t=1,2,...:
  // "slots" are ACCESS cycles with be=1. Slots 0..n-1 count down (rdy ignored),
  // slots n..n+s-1 see rdy=0, slot n+s completes. A hold inserted before slot d
  // drops be for h cycles, then spends one HOLD cycle with be=1: h+1 extra cycles.
  task automatic run_xfer(input bit rd, input int n, input logic [7:0] wd,
                          input logic [7:0] rv, input int s, input int d,
                          input int h, input bit cd_low, input string nm);
    int hold_len, tc, slot;
    bit in_hold;
    logic [19:0] o, e;
    hold_len = (h > 0) ? h + 1 : 0;
    tc = n + s + 1 + hold_len;   // last busy cycle; ack seen at tc+1
    @(posedge phi2); #1;
    req = 1'b1; rwb = rd; wait_cfg = WS_W'(n); core_wdata = wd; be = 1'b1;
    rdy_in = 1'($urandom); ext_din = 8'($urandom);
    @(negedge phi2);
    o = obs_vec(); e = {1'b0, 1'b0, 1'b0, 1'b1, m_wdata, m_rdata};
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL %s_idle got=%b exp=%b", nm, o, e); end
    if (!rd) m_wdata = wd;
    for (int t = 1; t <= tc + 1; t++) begin
      @(posedge phi2); #1;
      // Post-accept changes to the request inputs must not matter.
      req = 1'b0; rwb = 1'($urandom); wait_cfg = WS_W'($urandom);
      core_wdata = 8'($urandom); ext_din = 8'($urandom);
      in_hold = (h > 0) && (t - 1 >= d) && (t - 1 < d + hold_len);
      slot = (h > 0 && t - 1 >= d + hold_len) ? t - 1 - hold_len : t - 1;
      if (in_hold) begin
        be = (t - 1 < d + h) ? 1'b0 : 1'b1;
        rdy_in = 1'($urandom);
      end else begin
        be = 1'b1;
        if (slot < n)          rdy_in = cd_low ? 1'b0 : 1'($urandom);
        else if (slot < n + s) rdy_in = 1'b0;
        else                   rdy_in = 1'b1;
        if (slot == n + s && rd) ext_din = rv;
      end
      @(negedge phi2);
      if (t == tc + 1 && rd) m_rdata = rv;
      if (t <= tc) e = {1'b1, 1'b0, !rd && !in_hold, rd, m_wdata, m_rdata};
      else         e = {1'b0, 1'b1, 1'b0, 1'b1, m_wdata, m_rdata};
      o = obs_vec();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL %s_t%0d got=%b exp=%b", nm, t, o, e); end
    end
  endtask

  task automatic test_read_basic();
    run_xfer(1'b1, 0, 8'h00, 8'hA5, 0, 0, 0, 1'b0, "read_ws0");
  endtask

  task automatic test_write_waits();
    run_xfer(1'b0, 3, 8'h3C, 8'h00, 0, 0, 0, 1'b0, "write_ws3");
  endtask

  task automatic test_rdy_stretch();
    // rdy low through the countdown, then low 3 more cycles.
    run_xfer(1'b1, 1, 8'h00, 8'h96, 3, 0, 0, 1'b1, "read_rdy");
  endtask

  task automatic test_bus_hold();
    run_xfer(1'b0, 3, 8'hC3, 8'h00, 0, 1, 1, 1'b0, "write_hold1");
    run_xfer(1'b0, 2, 8'h81, 8'h00, 0, 2, 2, 1'b0, "write_hold2");
    // be falls exactly on the would-be completion cycle: be wins.
    run_xfer(1'b1, 1, 8'h00, 8'h4E, 1, 2, 1, 1'b0, "read_hold_done");
  endtask

  task automatic test_max_wait();
    run_xfer(1'b1, 15, 8'h00, 8'hE7, 0, 0, 0, 1'b1, "read_ws15");
  endtask

  task automatic test_random();
    int n, s, h, d;
    bit rd;
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom);
      n  = $urandom_range(0, 4);
      s  = $urandom_range(0, 3);
      h  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      d  = $urandom_range(0, n + s);
      run_xfer(rd, n, 8'($urandom), 8'($urandom), s, d, h, 1'b0, "rand");
    end
  endtask

  // read / write / read with req held; wait_cfg=0 so ack lands every 2 cycles.
  task automatic test_back_to_back();
    logic [7:0] rv0, wv1, rv2;
    logic [19:0] o, e;
    int k;
    rv0 = 8'h5D; wv1 = 8'hB2; rv2 = 8'h19;
    @(posedge phi2); #1;
    req = 1'b1; rwb = 1'b1; wait_cfg = '0; be = 1'b1; rdy_in = 1'b1;
    core_wdata = 8'($urandom);
    @(negedge phi2);
    for (int t = 1; t <= 7; t++) begin
      @(posedge phi2); #1;
      k = (t - 1) / 2;
      ext_din = (k == 0) ? rv0 : (k == 2) ? rv2 : 8'($urandom);
      if (t == 2) begin rwb = 1'b0; core_wdata = wv1; end
      if (t == 4) begin rwb = 1'b1; core_wdata = 8'($urandom); end
      if (t == 6) req = 1'b0;
      @(negedge phi2);
      if (t == 3) m_wdata = wv1;
      if (t == 2) m_rdata = rv0;
      if (t == 6) m_rdata = rv2;
      if (t == 7)        e = {1'b0, 1'b0, 1'b0, 1'b1, m_wdata, m_rdata};
      else if (t % 2)    e = {1'b1, 1'b0, k == 1, k != 1, m_wdata, m_rdata};
      else               e = {1'b0, 1'b1, 1'b0, 1'b1, m_wdata, m_rdata};
      o = obs_vec();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_t%0d got=%b exp=%b", t, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] o, e;
    @(posedge phi2); #1;
    req = 1'b1; rwb = 1'b0; wait_cfg = 4'd5; core_wdata = 8'h6B; be = 1'b1; rdy_in = 1'b1;
    @(posedge phi2); #1; req = 1'b0;
    @(posedge phi2); #1;
    @(negedge phi2);
    n_tests++;
    if (ext_oe !== 1'b1 || ext_dout !== 8'h6B) begin
      n_fail++; $display("FAIL rst_mid_pre got oe=%b dout=%h exp oe=1 dout=6b", ext_oe, ext_dout);
    end
    #2 resb = 1'b0;
    #1;
    m_wdata = '0; m_rdata = '0;
    o = obs_vec(); e = {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rst_mid_async got=%b exp=%b", o, e); end
    @(negedge phi2); resb = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge phi2);
      o = obs_vec();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL rst_mid_after%0d got=%b exp=%b", t, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_waits();
    test_rdy_stretch();
    test_bus_hold();
    test_max_wait();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
